// File: rtl/chipper_injector_q_if.sv
// Link/local-request bundle between the router link stage and chipper_injector_q.
// master drives link inputs and local requests; slave is the injector.
interface chipper_injector_q_if #(
    parameter int unsigned COORD_W    = 3,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned FLIT_W = 4 + 2 * COORD_W;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [FLIT_W-1:0]    in_n;
    logic [FLIT_W-1:0]    in_s;
    logic [FLIT_W-1:0]    in_e;
    logic [FLIT_W-1:0]    in_w;
    logic                 loc_valid;
    logic [2*COORD_W-1:0] loc_dest;
    logic                 loc_ready;
    logic [FLIT_W-1:0]    out_n;
    logic [FLIT_W-1:0]    out_s;
    logic [FLIT_W-1:0]    out_e;
    logic [FLIT_W-1:0]    out_w;
    logic                 inj_fire;
    logic                 err_self;
    logic [CNT_W-1:0]     fifo_count;

    modport master (
        output in_n, in_s, in_e, in_w, loc_valid, loc_dest,
        input  loc_ready, out_n, out_s, out_e, out_w, inj_fire, err_self, fifo_count
    );

    modport slave (
        input  in_n, in_s, in_e, in_w, loc_valid, loc_dest,
        output loc_ready, out_n, out_s, out_e, out_w, inj_fire, err_self, fifo_count
    );
endinterface

// File: rtl/chipper_injector_q.sv
// Registered local-injection stage for the bufferless deflection router.
// Define CHIPPER_INJ_RR_EN for rotating channel priority; default is fixed N>S>E>W.
module chipper_injector_q #(
    parameter int unsigned COORD_W    = 3,
    parameter int unsigned NODE_X     = 4,
    parameter int unsigned NODE_Y     = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    chipper_injector_q_if.slave bus
);
    localparam int unsigned FLIT_W = 4 + 2 * COORD_W;
    localparam int unsigned DEST_W = 2 * COORD_W;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam logic [COORD_W-1:0] SELF_COL = COORD_W'(NODE_X);
    localparam logic [COORD_W-1:0] SELF_ROW = COORD_W'(NODE_Y);

    // Channel index order: 0=N, 1=S, 2=E, 3=W
    logic [FLIT_W-1:0] in_flit [4];
    logic [FLIT_W-1:0] out_q   [4];
    logic [FLIT_W-1:0] out_d   [4];
    logic [3:0]        empty_mask;

    logic [DEST_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              inj_fire_q, err_self_q;

    logic              push, self_req, store, do_pop, fifo_empty;
    logic              grant_valid;
    logic [1:0]        grant;
    logic [DEST_W-1:0] head;
    logic [COORD_W-1:0] head_row, head_col;
    logic [2:0]        head_dir;

    assign in_flit[0] = bus.in_n;
    assign in_flit[1] = bus.in_s;
    assign in_flit[2] = bus.in_e;
    assign in_flit[3] = bus.in_w;

    assign bus.out_n      = out_q[0];
    assign bus.out_s      = out_q[1];
    assign bus.out_e      = out_q[2];
    assign bus.out_w      = out_q[3];
    assign bus.inj_fire   = inj_fire_q;
    assign bus.err_self   = err_self_q;
    assign bus.fifo_count = count_q;
    assign bus.loc_ready  = count_q < CNT_W'(FIFO_DEPTH);

    assign fifo_empty = count_q == '0;
    assign push       = bus.loc_valid && bus.loc_ready;
    assign self_req   = bus.loc_dest == {SELF_ROW, SELF_COL};
    assign store      = push && !self_req;

    assign head     = mem_q[rd_ptr_q];
    assign head_row = head[DEST_W-1:COORD_W];
    assign head_col = head[COORD_W-1:0];

    // XY routing: resolve the column first, then the row
    always_comb begin
        head_dir = 3'b011;
        if (head_col > SELF_COL) begin
            head_dir = 3'b000;
        end else if (head_col < SELF_COL) begin
            head_dir = 3'b001;
        end else if (head_row > SELF_ROW) begin
            head_dir = 3'b010;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            empty_mask[i] = ~in_flit[i][FLIT_W-1];
        end
    end

`ifdef CHIPPER_INJ_RR_EN
    logic [1:0] rr_ptr_q;

    always_comb begin
        grant_valid = 1'b0;
        grant       = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (!grant_valid && empty_mask[rr_ptr_q + 2'(k)]) begin
                grant_valid = 1'b1;
                grant       = rr_ptr_q + 2'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 2'd0;
        end else if (do_pop) begin
            rr_ptr_q <= grant + 2'd1;
        end
    end
`else
    always_comb begin
        grant_valid = 1'b0;
        grant       = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (empty_mask[k]) begin
                grant_valid = 1'b1;
                grant       = 2'(k);
            end
        end
    end
`endif

    assign do_pop = grant_valid && !fifo_empty;

    // Empty slots are zeroed so stale payload bits never reach the arbiter
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            out_d[i] = empty_mask[i] ? '0 : in_flit[i];
        end
        if (do_pop) begin
            out_d[grant] = {1'b1, head_dir, head};
        end
    end

    always_comb begin
        count_d = count_q;
        case ({store, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                out_q[i] <= '0;
            end
            inj_fire_q <= 1'b0;
            err_self_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                out_q[i] <= out_d[i];
            end
            inj_fire_q <= do_pop;
            err_self_q <= push && self_req;
            count_q    <= count_d;
            if (store) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (store) begin
            mem_q[wr_ptr_q] <= bus.loc_dest;
        end
    end
endmodule
